// File: rtl/generals_rand_pkg.sv
// Shared types and default widths for the random drawer and its reduction unit.
package generals_rand_pkg;
  localparam int SEED_WIDTH = 10;
  localparam int OUT_WIDTH  = 8;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    REDUCE,
    CHECK,
    DONE
  } draw_state_t;
endpackage

// File: rtl/random_drawer_if.sv
// Request/candidate/result bundle between the drawer, its requester and the checker.
interface random_drawer_if #(
  parameter int SEED_WIDTH = generals_rand_pkg::SEED_WIDTH,
  parameter int OUT_WIDTH  = generals_rand_pkg::OUT_WIDTH
);
  import generals_rand_pkg::*;

  logic [SEED_WIDTH-1:0] seed_i;
  logic                  req_i;
  logic [OUT_WIDTH-1:0]  bound_i;
  logic                  busy_o;
  logic                  cand_valid_o;
  logic [OUT_WIDTH-1:0]  cand_o;
  logic                  cand_ok_i;
  logic                  cand_bad_i;
  logic                  done_o;
  logic                  fail_o;
  logic [OUT_WIDTH-1:0]  result_o;
  draw_state_t           dbg_state;

  // Handshake: req_i is taken only while busy_o is low; a candidate is
  // answered by cand_ok_i or cand_bad_i (bad wins) while cand_valid_o is high;
  // done_o pulses one cycle with fail_o qualifying it.
  modport master (
    output seed_i, req_i, bound_i, cand_ok_i, cand_bad_i,
    input  busy_o, cand_valid_o, cand_o, done_o, fail_o, result_o, dbg_state
  );

  modport slave (
    input  seed_i, req_i, bound_i, cand_ok_i, cand_bad_i,
    output busy_o, cand_valid_o, cand_o, done_o, fail_o, result_o, dbg_state
  );
endinterface

// File: rtl/random_drawer_seq_mod_unit.sv
// Bit-serial restoring remainder: dividend mod divisor, one dividend bit per cycle, MSB first.
module seq_mod_unit #(
  parameter int SEED_WIDTH = generals_rand_pkg::SEED_WIDTH,
  parameter int OUT_WIDTH  = generals_rand_pkg::OUT_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SEED_WIDTH-1:0] dividend,
  input  logic [OUT_WIDTH-1:0]  divisor,
  output logic                  done,
  output logic [OUT_WIDTH-1:0]  remainder
);
  localparam int CW = $clog2(SEED_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(SEED_WIDTH - 1);

  logic [SEED_WIDTH-1:0] sh_q, sh_d;
  logic [OUT_WIDTH:0]    rem_q, rem_d;
  logic [OUT_WIDTH:0]    trial, step;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  run_q, run_d;

  always_comb begin
    trial     = {rem_q[OUT_WIDTH-1:0], sh_q[SEED_WIDTH-1]};
    step      = (trial >= {1'b0, divisor}) ? trial - {1'b0, divisor} : trial;
    sh_d      = sh_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    run_d     = run_q;
    done      = 1'b0;
    remainder = step[OUT_WIDTH-1:0];
    if (start) begin
      sh_d  = dividend;
      rem_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      rem_d = step;
      sh_d  = sh_q << 1;
      cnt_d = cnt_q + 1'b1;
      // done flags the final step so the caller can capture remainder on this edge
      if (cnt_q == LAST) begin
        run_d = 1'b0;
        done  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sh_q  <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end
endmodule

// File: rtl/random_drawer.sv
// Draws seed mod bound from the live counter, offering each candidate to a checker with bounded retries.
module random_drawer #(
  parameter int SEED_WIDTH = generals_rand_pkg::SEED_WIDTH,
  parameter int OUT_WIDTH  = generals_rand_pkg::OUT_WIDTH,
  parameter int MAX_RETRY  = 15
) (
  input  logic            clock,
  input  logic            reset,
  random_drawer_if.slave  bus
);
  import generals_rand_pkg::*;

  draw_state_t          state_q, state_d;
  logic [OUT_WIDTH-1:0] bound_q, bound_d;
  logic [3:0]           retry_q, retry_d;
  logic [OUT_WIDTH-1:0] cand_q, cand_d;
  logic [OUT_WIDTH-1:0] result_q, result_d;
  logic                 busy_q, busy_d;
  logic                 cand_valid_q, cand_valid_d;
  logic                 done_q, done_d;
  logic                 fail_q, fail_d;
  logic                 sm_start, sm_done;
  logic [OUT_WIDTH-1:0] sm_rem;

  seq_mod_unit #(.SEED_WIDTH(SEED_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_mod (
    .clock     (clock),
    .reset     (reset),
    .start     (sm_start),
    .dividend  (bus.seed_i),
    .divisor   (bound_q),
    .done      (sm_done),
    .remainder (sm_rem)
  );

  always_comb begin
    state_d  = state_q;
    bound_d  = bound_q;
    retry_d  = retry_q;
    cand_d   = cand_q;
    result_d = result_q;
    fail_d   = 1'b0;
    sm_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          if (bus.bound_i != '0) begin
            bound_d = bus.bound_i;
            retry_d = '0;
            state_d = SAMPLE;
          end else begin
            fail_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      SAMPLE: begin
        sm_start = 1'b1;
        state_d  = REDUCE;
      end
      REDUCE: begin
        if (sm_done) begin
          cand_d  = sm_rem;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // a rejection wins over a simultaneous accept
        if (bus.cand_bad_i) begin
          retry_d = retry_q + 4'd1;
          if (retry_d == 4'(MAX_RETRY)) begin
            fail_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = SAMPLE;
          end
        end else if (bus.cand_ok_i) begin
          result_d = cand_q;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d       = (state_d != IDLE);
    cand_valid_d = (state_d == CHECK);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bound_q      <= '0;
      retry_q      <= '0;
      cand_q       <= '0;
      result_q     <= '0;
      busy_q       <= 1'b0;
      cand_valid_q <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bound_q      <= bound_d;
      retry_q      <= retry_d;
      cand_q       <= cand_d;
      result_q     <= result_d;
      busy_q       <= busy_d;
      cand_valid_q <= cand_valid_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
    end
  end

  assign bus.busy_o       = busy_q;
  assign bus.cand_valid_o = cand_valid_q;
  assign bus.cand_o       = cand_q;
  assign bus.done_o       = done_q;
  assign bus.fail_o       = fail_q;
  assign bus.result_o     = result_q;
  assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_random_drawer.sv
// Scenario bench for random_drawer: fixed cases plus randomized draws checked against seed % bound.
module tb_random_drawer;
  import generals_rand_pkg::*;

  localparam int SW  = 10;
  localparam int OW  = 8;
  localparam int MR  = 3;
  localparam int LAT = 1 + SW;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  logic [OW-1:0] exp_q[$];

  random_drawer_if #(.SEED_WIDTH(SW), .OUT_WIDTH(OW)) bus ();

  random_drawer #(.SEED_WIDTH(SW), .OUT_WIDTH(OW), .MAX_RETRY(MR)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [OW-1:0] ref_draw(input int s, input int b);
    return OW'(s % b);
  endfunction

  task automatic start_draw(input int s, input int b);
    @(negedge clock);
    bus.seed_i  = SW'(s);
    bus.bound_i = OW'(b);
    bus.req_i   = 1'b1;
    @(negedge clock);
    bus.req_i   = 1'b0;
  endtask

  task automatic wait_cand(output int cyc);
    cyc = 0;
    while (!bus.cand_valid_o && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic respond(input logic ok, input logic rej, input int next_seed);
    bus.cand_ok_i  = ok;
    bus.cand_bad_i = rej;
    bus.seed_i     = SW'(next_seed);
    @(negedge clock);
    bus.cand_ok_i  = 1'b0;
    bus.cand_bad_i = 1'b0;
  endtask

  task automatic test_reset;
    reset        = 1'b1;
    bus.seed_i   = '0;
    bus.req_i    = 1'b0;
    bus.bound_i  = '0;
    bus.cand_ok_i  = 1'b0;
    bus.cand_bad_i = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if ({bus.busy_o, bus.cand_valid_o, bus.done_o, bus.fail_o} !== 4'b0 ||
        bus.cand_o !== 8'd0 || bus.result_o !== 8'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b cv=%b done=%b fail=%b cand=%0d res=%0d want all 0",
               bus.busy_o, bus.cand_valid_o, bus.done_o, bus.fail_o, bus.cand_o, bus.result_o);
    end
    total++;
    if (bus.dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset_state: got %0d want %0d", bus.dbg_state, IDLE);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int cyc;
    logic [OW-1:0] e;
    exp_q.push_back(ref_draw(1000, 7));
    start_draw(1000, 7);
    wait_cand(cyc);
    total++;
    if (cyc !== LAT) begin bad++; $display("FAIL basic_latency: got %0d want %0d", cyc, LAT); end
    e = exp_q.pop_front();
    total++;
    if (bus.cand_o !== e) begin bad++; $display("FAIL basic_cand: got %0d want %0d", bus.cand_o, e); end
    respond(1'b1, 1'b0, 1000);
    total++;
    if (bus.done_o !== 1'b1 || bus.fail_o !== 1'b0 || bus.result_o !== e) begin
      bad++;
      $display("FAIL basic_done: got done=%b fail=%b res=%0d want 1 0 %0d", bus.done_o, bus.fail_o, bus.result_o, e);
    end
    @(negedge clock);
    total++;
    if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      bad++;
      $display("FAIL basic_pulse: got done=%b busy=%b want 0 0", bus.done_o, bus.busy_o);
    end
  endtask

  task automatic test_edges;
    int seeds[3]  = '{1023, 0, 517};
    int bounds[3] = '{255, 200, 1};
    int cyc;
    logic [OW-1:0] e;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ref_draw(seeds[i], bounds[i]));
      start_draw(seeds[i], bounds[i]);
      wait_cand(cyc);
      total++;
      if (cyc !== LAT) begin bad++; $display("FAIL edge_latency[%0d]: got %0d want %0d", i, cyc, LAT); end
      e = exp_q.pop_front();
      total++;
      if (bus.cand_o !== e) begin bad++; $display("FAIL edge_cand[%0d]: got %0d want %0d", i, bus.cand_o, e); end
      respond(1'b1, 1'b0, seeds[i]);
      total++;
      if (bus.done_o !== 1'b1 || bus.fail_o !== 1'b0 || bus.result_o !== e) begin
        bad++;
        $display("FAIL edge_done[%0d]: got done=%b fail=%b res=%0d want 1 0 %0d", i, bus.done_o, bus.fail_o, bus.result_o, e);
      end
    end
  endtask

  task automatic test_rejection;
    int seeds[3] = '{123, 456, 789};
    int cyc;
    logic [OW-1:0] e;
    for (int i = 0; i < 3; i++) exp_q.push_back(ref_draw(seeds[i], 10));
    start_draw(seeds[0], 10);
    for (int i = 0; i < 3; i++) begin
      wait_cand(cyc);
      total++;
      if (cyc !== LAT) begin bad++; $display("FAIL rej_latency[%0d]: got %0d want %0d", i, cyc, LAT); end
      e = exp_q.pop_front();
      total++;
      if (bus.cand_o !== e) begin bad++; $display("FAIL rej_cand[%0d]: got %0d want %0d", i, bus.cand_o, e); end
      if (i < 2) begin
        respond(1'b0, 1'b1, seeds[i+1]);
        total++;
        if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b1) begin
          bad++;
          $display("FAIL rej_resample[%0d]: got done=%b busy=%b want 0 1", i, bus.done_o, bus.busy_o);
        end
      end else begin
        respond(1'b1, 1'b0, seeds[i]);
        total++;
        if (bus.done_o !== 1'b1 || bus.fail_o !== 1'b0 || bus.result_o !== e) begin
          bad++;
          $display("FAIL rej_accept: got done=%b fail=%b res=%0d want 1 0 %0d", bus.done_o, bus.fail_o, bus.result_o, e);
        end
      end
    end
  endtask

  task automatic test_simultaneous;
    int cyc;
    logic [OW-1:0] e;
    start_draw(44, 10);
    wait_cand(cyc);
    respond(1'b1, 1'b1, 58);
    total++;
    if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      bad++;
      $display("FAIL simul_is_reject: got done=%b busy=%b want 0 1", bus.done_o, bus.busy_o);
    end
    e = ref_draw(58, 10);
    wait_cand(cyc);
    total++;
    if (cyc !== LAT || bus.cand_o !== e) begin
      bad++;
      $display("FAIL simul_resample: got lat=%0d cand=%0d want %0d %0d", cyc, bus.cand_o, LAT, e);
    end
    respond(1'b1, 1'b0, 58);
    total++;
    if (bus.done_o !== 1'b1 || bus.fail_o !== 1'b0 || bus.result_o !== e) begin
      bad++;
      $display("FAIL simul_accept: got done=%b fail=%b res=%0d want 1 0 %0d", bus.done_o, bus.fail_o, bus.result_o, e);
    end
  endtask

  task automatic test_exhaust;
    int cyc;
    logic [OW-1:0] prev;
    prev = ref_draw(58, 10);
    start_draw(91, 13);
    for (int i = 0; i < MR; i++) begin
      wait_cand(cyc);
      total++;
      if (cyc !== LAT) begin bad++; $display("FAIL exh_latency[%0d]: got %0d want %0d", i, cyc, LAT); end
      respond(i == 1, 1'b1, 200 + i);
      if (i < MR - 1) begin
        total++;
        if (bus.done_o !== 1'b0) begin bad++; $display("FAIL exh_early_done[%0d]: got %b want 0", i, bus.done_o); end
      end
    end
    total++;
    if (bus.done_o !== 1'b1 || bus.fail_o !== 1'b1 || bus.result_o !== prev) begin
      bad++;
      $display("FAIL exh_fail: got done=%b fail=%b res=%0d want 1 1 %0d", bus.done_o, bus.fail_o, bus.result_o, prev);
    end
    @(negedge clock);
    total++;
    if (bus.fail_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      bad++;
      $display("FAIL exh_clear: got fail=%b busy=%b want 0 0", bus.fail_o, bus.busy_o);
    end
  endtask

  task automatic test_zero_bound;
    logic [OW-1:0] prev;
    prev = bus.result_o;
    start_draw(300, 0);
    total++;
    if (bus.done_o !== 1'b1 || bus.fail_o !== 1'b1 || bus.busy_o !== 1'b1 || bus.result_o !== prev) begin
      bad++;
      $display("FAIL zero_done: got done=%b fail=%b busy=%b res=%0d want 1 1 1 %0d",
               bus.done_o, bus.fail_o, bus.busy_o, bus.result_o, prev);
    end
    @(negedge clock);
    total++;
    if (bus.done_o !== 1'b0 || bus.fail_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      bad++;
      $display("FAIL zero_after: got done=%b fail=%b busy=%b want 0 0 0", bus.done_o, bus.fail_o, bus.busy_o);
    end
  endtask

  task automatic test_req_held;
    int cyc;
    int drops;
    logic [OW-1:0] e;
    e = ref_draw(1000, 7);
    drops = 0;
    @(negedge clock);
    bus.seed_i  = SW'(1000);
    bus.bound_i = OW'(7);
    bus.req_i   = 1'b1;
    @(negedge clock);
    bus.bound_i = OW'(3);
    cyc = 0;
    while (!bus.cand_valid_o && cyc < 100) begin
      if (!bus.busy_o) drops++;
      @(negedge clock);
      cyc++;
    end
    total++;
    if (cyc !== LAT || drops !== 0 || bus.cand_o !== e) begin
      bad++;
      $display("FAIL held_draw: got lat=%0d drops=%0d cand=%0d want %0d 0 %0d", cyc, drops, bus.cand_o, LAT, e);
    end
    respond(1'b1, 1'b0, 1000);
    total++;
    if (bus.done_o !== 1'b1 || bus.result_o !== e) begin
      bad++;
      $display("FAIL held_done: got done=%b res=%0d want 1 %0d", bus.done_o, bus.result_o, e);
    end
    bus.req_i = 1'b0;
    @(negedge clock);
    total++;
    if (bus.busy_o !== 1'b0 || bus.cand_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL held_idle: got busy=%b cv=%b want 0 0", bus.busy_o, bus.cand_valid_o);
    end
  endtask

  task automatic test_async_reset;
    int cyc;
    logic [OW-1:0] e;
    start_draw(777, 9);
    repeat (4) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({bus.busy_o, bus.cand_valid_o, bus.done_o, bus.fail_o} !== 4'b0 ||
        bus.cand_o !== 8'd0 || bus.result_o !== 8'd0 || bus.dbg_state !== IDLE) begin
      bad++;
      $display("FAIL async_reset: got busy=%b cv=%b done=%b fail=%b cand=%0d res=%0d want all 0",
               bus.busy_o, bus.cand_valid_o, bus.done_o, bus.fail_o, bus.cand_o, bus.result_o);
    end
    @(negedge clock);
    reset = 1'b0;
    e = ref_draw(777, 9);
    start_draw(777, 9);
    wait_cand(cyc);
    total++;
    if (cyc !== LAT || bus.cand_o !== e) begin
      bad++;
      $display("FAIL async_redraw: got lat=%0d cand=%0d want %0d %0d", cyc, bus.cand_o, LAT, e);
    end
    respond(1'b1, 1'b0, 777);
    total++;
    if (bus.done_o !== 1'b1 || bus.result_o !== e) begin
      bad++;
      $display("FAIL async_result: got done=%b res=%0d want 1 %0d", bus.done_o, bus.result_o, e);
    end
  endtask

  task automatic test_random;
    int s, b, nrej, cyc, nxt;
    logic [OW-1:0] e;
    for (int it = 0; it < 10; it++) begin
      s    = $urandom_range(0, 1023);
      b    = $urandom_range(1, 255);
      nrej = $urandom_range(0, MR - 1);
      exp_q.push_back(ref_draw(s, b));
      start_draw(s, b);
      for (int r = 0; r <= nrej; r++) begin
        wait_cand(cyc);
        e = exp_q.pop_front();
        total++;
        if (cyc !== LAT || bus.cand_o !== e) begin
          bad++;
          $display("FAIL rand_cand[%0d.%0d]: got lat=%0d cand=%0d want %0d %0d", it, r, cyc, bus.cand_o, LAT, e);
        end
        if (r < nrej) begin
          nxt = $urandom_range(0, 1023);
          exp_q.push_back(ref_draw(nxt, b));
          respond(1'b0, 1'b1, nxt);
        end else begin
          respond(1'b1, 1'b0, s);
          total++;
          if (bus.done_o !== 1'b1 || bus.fail_o !== 1'b0 || bus.result_o !== e) begin
            bad++;
            $display("FAIL rand_result[%0d]: got done=%b fail=%b res=%0d want 1 0 %0d",
                     it, bus.done_o, bus.fail_o, bus.result_o, e);
          end
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_edges();
    test_rejection();
    test_simultaneous();
    test_exhaust();
    test_zero_bound();
    test_req_held();
    test_async_reset();
    test_random();
    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
